// File: rtl/bip_pkg.sv
// bip_pkg: shared opcodes, datapath select encodings, FSM state codes and control bundle for the BIP control unit
package bip_pkg;
    localparam logic [4:0] OPC_HLT  = 5'd0;
    localparam logic [4:0] OPC_STO  = 5'd1;
    localparam logic [4:0] OPC_LD   = 5'd2;
    localparam logic [4:0] OPC_LDI  = 5'd3;
    localparam logic [4:0] OPC_ADD  = 5'd4;
    localparam logic [4:0] OPC_ADDI = 5'd5;
    localparam logic [4:0] OPC_SUB  = 5'd6;
    localparam logic [4:0] OPC_SUBI = 5'd7;
    localparam logic [1:0] SRC_DM  = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_ALU = 2'd2;
    localparam logic SELB_IMM = 1'b0;
    localparam logic SELB_DM  = 1'b1;
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    typedef struct packed {
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_hlt;
    } ctrl_t;
endpackage

// File: rtl/bip_control_decoder.sv
// bip_decoder: combinational opcode to control-bundle map
//   i_opc  in  5        instruction opcode
//   o_ctl  out ctrl_t   {wr_acc, sel_a, sel_b, op, wr_ram, rd_ram, is_hlt}
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opc,
    output ctrl_t      o_ctl
);
    logic w_alu;
    assign w_alu = i_opc inside {OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI};
    always_comb begin
        o_ctl.wr_acc = w_alu || i_opc == OPC_LD || i_opc == OPC_LDI;
        o_ctl.sel_a  = (i_opc == OPC_LDI) ? SRC_IMM : w_alu ? SRC_ALU : SRC_DM;
        o_ctl.sel_b  = (i_opc == OPC_ADD || i_opc == OPC_SUB) ? SELB_DM : SELB_IMM;
        o_ctl.op     = (i_opc == OPC_SUB || i_opc == OPC_SUBI) ? ALU_SUB : ALU_ADD;
        o_ctl.wr_ram = i_opc == OPC_STO;
        o_ctl.rd_ram = i_opc inside {OPC_LD, OPC_ADD, OPC_SUB};
        o_ctl.is_hlt = i_opc == OPC_HLT;
    end
endmodule

// File: rtl/bip_control.sv
// bip_control: three-cycle FETCH/DECODE/EXEC control unit for the BIP accumulator processor
//   CLK, RESET_N     clock, asynchronous active-low reset
//   START            one-cycle pulse that leaves IDLE
//   PM_DATA/PM_ADDR  synchronous program memory (PM_ADDR = PC)
//   DM_ADDR, RD_RAM, WR_RAM          data memory address and strobes
//   OPERAND, SEL_A, SEL_B, OP, WR_ACC datapath controls
//   HALTED, CYCLE_CNT                status for the debug unit
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [15:0]      PM_DATA,
    output logic [PC_W-1:0]  PM_ADDR,
    output logic [PC_W-1:0]  DM_ADDR,
    output logic             RD_RAM,
    output logic             WR_RAM,
    output logic [10:0]      OPERAND,
    output logic [1:0]       SEL_A,
    output logic             SEL_B,
    output logic             OP,
    output logic             WR_ACC,
    output logic             HALTED,
    output logic [CNT_W-1:0] CYCLE_CNT
);
    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [PC_W-1:0]  r_pc;
    logic [15:0]      r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;
    logic             w_exe;
    logic             w_busy;
    logic [4:0]       w_opc;
    ctrl_t            w_ctl;
    assign w_dec  = r_state == S_DECODE;
    assign w_exe  = r_state == S_EXEC;
    assign w_busy = w_dec || w_exe || r_state == S_FETCH;
    // One decoder serves both phases: the incoming word in DECODE, the latched IR in EXEC.
    assign w_opc  = w_dec ? PM_DATA[15:11] : r_ir[15:11];
    bip_decoder u_dec (
        .i_opc(w_opc),
        .o_ctl(w_ctl)
    );
    always_comb begin
        w_next = (r_state == S_IDLE)   ? (START ? S_FETCH : S_IDLE) :
                 (r_state == S_FETCH)  ? S_DECODE :
                 (r_state == S_DECODE) ? (w_ctl.is_hlt ? S_HALT : S_EXEC) :
                 (r_state == S_EXEC)   ? S_FETCH : S_HALT;
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_dec) r_ir <= PM_DATA;
            if (w_exe) r_pc <= r_pc + PC_W'(1);
            if (w_busy && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    // Strobes decode straight from the state register so an asynchronous reset clears them at once.
    assign PM_ADDR   = r_pc;
    assign DM_ADDR   = w_dec ? PC_W'(PM_DATA[10:0]) : w_exe ? PC_W'(r_ir[10:0]) : '0;
    assign RD_RAM    = w_dec && w_ctl.rd_ram;
    assign WR_RAM    = w_exe && w_ctl.wr_ram;
    assign WR_ACC    = w_exe && w_ctl.wr_acc;
    assign SEL_A     = w_exe ? w_ctl.sel_a : SRC_DM;
    assign SEL_B     = w_exe ? w_ctl.sel_b : SELB_IMM;
    assign OP        = w_exe ? w_ctl.op : ALU_ADD;
    assign OPERAND   = r_ir[10:0];
    assign HALTED    = r_state == S_HALT;
    assign CYCLE_CNT = r_cnt;
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: randomized and directed instruction-level checks of bip_control against a program-level reference model
module tb_bip_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] pm_q, pm_q2;
    logic [10:0] pm_addr, dm_addr, operand, operand2;
    logic        rd_ram, wr_ram, sel_b, op, wr_acc, halted;
    logic [1:0]  sel_a, sel_a2;
    logic [31:0] cycle_cnt;
    logic [3:0]  pm_addr2, dm_addr2, cnt2;
    logic        rd2, wr2, sel_b2, op2, wr_acc2, halted2;
    logic [15:0] pm [0:2047];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        pm_q  <= pm[pm_addr];
        pm_q2 <= pm[{7'd0, pm_addr2}];
    end
    bip_control dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .PM_DATA(pm_q),
        .PM_ADDR(pm_addr), .DM_ADDR(dm_addr), .RD_RAM(rd_ram), .WR_RAM(wr_ram),
        .OPERAND(operand), .SEL_A(sel_a), .SEL_B(sel_b), .OP(op), .WR_ACC(wr_acc),
        .HALTED(halted), .CYCLE_CNT(cycle_cnt)
    );
    bip_control #(.PC_W(4), .CNT_W(4)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .START(start2), .PM_DATA(pm_q2),
        .PM_ADDR(pm_addr2), .DM_ADDR(dm_addr2), .RD_RAM(rd2), .WR_RAM(wr2),
        .OPERAND(operand2), .SEL_A(sel_a2), .SEL_B(sel_b2), .OP(op2), .WR_ACC(wr_acc2),
        .HALTED(halted2), .CYCLE_CNT(cnt2)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [18:0] obs();
        return {halted, rd_ram, wr_ram, wr_acc, sel_a, sel_b, op, dm_addr};
    endfunction
    // EXEC controls per instruction: {wr_ram, wr_acc, sel_a, sel_b, op}
    function automatic logic [5:0] exec_ctl(input logic [4:0] opc);
        case (opc)
            5'd1:    return 6'b1_0_00_0_0;
            5'd2:    return 6'b0_1_00_0_0;
            5'd3:    return 6'b0_1_01_0_0;
            5'd4:    return 6'b0_1_10_1_0;
            5'd5:    return 6'b0_1_10_0_0;
            5'd6:    return 6'b0_1_10_1_1;
            5'd7:    return 6'b0_1_10_0_1;
            default: return 6'b0;
        endcase
    endfunction
    function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] opd);
        return {opc, opd};
    endfunction
    task automatic fill(input logic [4:0] opc);
        for (int i = 0; i < 2048; i++) pm[i] = enc(opc, 11'($urandom));
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        #1;
        chk("rst_bundle", 32'(obs()), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    // Instruction-level model: each instruction spends one cycle each in fetch, decode, execute;
    // HLT stops after decode. PC, cycle count and the expected control bundle follow from the program.
    task automatic run(input int max_i, input bit rnd_start, output int edges, output int cnt_hd);
        int pc = 0;
        int cnt = 0;
        int k = -1;
        logic [15:0] ir;
        bit done = 0;
        edges = 0;
        cnt_hd = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < max_i && !done; n++) begin
            @(negedge clk); k++;
            if (rnd_start) start = 1'($urandom);
            chk("fetch_bundle", 32'(obs()), 32'd0);
            chk("fetch_pc", 32'(pm_addr), 32'(pc));
            chk("fetch_cnt", cycle_cnt, 32'(cnt));
            cnt++;
            ir = pm[pc];
            @(negedge clk); k++;
            if (rnd_start) start = 1'($urandom);
            chk("decode_bundle", 32'(obs()),
                32'({1'b0, ir[15:11] == 5'd2 || ir[15:11] == 5'd4 || ir[15:11] == 5'd6, 6'b0, ir[10:0]}));
            chk("decode_cnt", cycle_cnt, 32'(cnt));
            cnt++;
            if (ir[15:11] == 5'd0) begin
                cnt_hd = cycle_cnt;
                @(negedge clk); k++;
                chk("halt_bundle", 32'(obs()), 32'(19'h40000));
                chk("halt_pc", 32'(pm_addr), 32'(pc));
                chk("halt_cnt", cycle_cnt, 32'(cnt));
                edges = k;
                done = 1;
            end else begin
                @(negedge clk); k++;
                if (rnd_start) start = 1'($urandom);
                chk("exec_bundle", 32'(obs()), 32'({2'b0, exec_ctl(ir[15:11]), ir[10:0]}));
                chk("exec_operand", 32'(operand), 32'(ir[10:0]));
                chk("exec_cnt", cycle_cnt, 32'(cnt));
                cnt++;
                pc = (pc + 1) % 2048;
            end
        end
        start = 1'b0;
    endtask
    initial begin
        int edges, cnt_hd, n;
        fill(5'd8);
        do_reset();
        repeat (10) begin
            @(negedge clk);
            chk("idle_pm_addr", 32'(pm_addr), 32'd0);
            chk("idle_cnt", cycle_cnt, 32'd0);
            chk("idle_bundle", 32'(obs()), 32'd0);
        end
        // Narrow counter instance: saturates at 15 while running NOPs.
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("sat_cnt", 32'(cnt2), (k < 15) ? 32'(k) : 32'd15);
        end
        chk("idle_while_other", 32'(pm_addr), 32'd0);
        fill(5'd0);
        pm[0] = enc(5'd3, 11'd5);
        pm[1] = enc(5'd5, 11'd3);
        pm[2] = enc(5'd1, 11'd7);
        do_reset();
        run(10, 1'b0, edges, cnt_hd);
        chk("halt_edge", 32'(edges), 32'd11);
        chk("cnt_at_hlt_decode", 32'(cnt_hd), 32'd10);
        chk("final_cnt", cycle_cnt, 32'd11);
        chk("final_pc", 32'(pm_addr), 32'd3);
        fill(5'd0);
        pm[0] = enc(5'd2, 11'd2);
        pm[1] = enc(5'd6, 11'd4);
        do_reset();
        run(10, 1'b0, edges, cnt_hd);
        chk("mem_pc", 32'(pm_addr), 32'd2);
        fill(5'd0);
        pm[0] = enc(5'd31, 11'h555);
        do_reset();
        run(10, 1'b0, edges, cnt_hd);
        chk("illegal_pc", 32'(pm_addr), 32'd1);
        chk("illegal_halted", 32'(halted), 32'd1);
        repeat (6) begin
            fill(5'd0);
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) pm[i] = enc(5'($urandom_range(1, 31)), 11'($urandom));
            do_reset();
            run(n + 1, 1'b1, edges, cnt_hd);
            chk("rnd_pc", 32'(pm_addr), 32'(n));
            chk("rnd_halted", 32'(halted), 32'd1);
        end
        fill(5'd8);
        do_reset();
        run(2048, 1'b0, edges, cnt_hd);
        @(negedge clk);
        chk("wrap_pm_addr", 32'(pm_addr), 32'd0);
        fill(5'd0);
        pm[0] = enc(5'd8, 11'd1);
        pm[1] = enc(5'd1, 11'd9);
        do_reset();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("sto_wr", 32'(wr_ram), 32'd1);
        chk("sto_pc", 32'(pm_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr", 32'(wr_ram), 32'd0);
        chk("abort_pm_addr", 32'(pm_addr), 32'd0);
        chk("abort_bundle", 32'(obs()), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_abort_pc", 32'(pm_addr), 32'd0);
            chk("post_abort_cnt", cycle_cnt, 32'd0);
            chk("post_abort_bundle", 32'(obs()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
